// File: rtl/kbd_console_mcu.sv
`default_nettype none
// ============================================================================
// Module      : kbd_console_mcu
// Description : Polls the keyboard port over the shared memory bus, buffers
//               key codes in a small FIFO and writes them as console
//               characters (printable, newline, backspace) into VGA character
//               memory at a tracked cursor, with row/screen wrap-around.
//               Optional macro KBD_CONSOLE_CLEAR_EN: after reset, fill every
//               character cell with a space before echoing keys.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_console_mcu #(
  parameter int                 WORD_W     = 32,
  parameter logic [WORD_W-1:0]  KBD_ADDR   = 32'h0000_1000,
  parameter logic [WORD_W-1:0]  VGA_BASE   = 32'h0000_2000,
  parameter int                 COLS       = 80,
  parameter int                 ROWS       = 30,
  parameter int                 FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_W-1:0]             r_data,
  input  logic                          r_ready,
  input  logic                          w_ready,
  output logic                          r_enable,
  output logic [WORD_W-1:0]             r_addr,
  output logic [2:0]                    r_mode,
  output logic                          w_enable,
  output logic [WORD_W-1:0]             w_addr,
  output logic [WORD_W-1:0]             w_data,
  output logic [2:0]                    w_mode,
  output logic [$clog2(ROWS)-1:0]       cursor_row,
  output logic [$clog2(COLS)-1:0]       cursor_col,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(COLS - 1);
  localparam logic [LVL_W-1:0] C_FULL     = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       C_NL       = 8'h0A;
  localparam logic [7:0]       C_BS       = 8'h08;
  localparam logic [7:0]       C_SP       = 8'h20;

  typedef enum logic [0:0] {R_IDLE, R_REQ} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DEC, W_REQ, W_CLR} wr_state_t;

  rd_state_t         r_rd_state, w_rd_state_nx;
  wr_state_t         r_wr_state, w_wr_state_nx;
  logic              w_r_enable_nx, w_push, w_pop;
  logic [7:0]        r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [7:0]        r_code, w_code_nx;
  logic              r_is_print, w_is_print_nx;
  logic              w_w_enable_nx;
  logic [WORD_W-1:0] w_w_addr_nx, w_w_data_nx;
  logic [ROW_W-1:0]  w_row_nx;
  logic [COL_W-1:0]  w_col_nx;
`ifdef KBD_CONSOLE_CLEAR_EN
  logic              r_clearing, w_clearing_nx;
  logic [WORD_W-1:0] r_clr_idx, w_clr_idx_nx;
`endif

  // Only the low byte of a keyboard read carries a key code
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, r_data[WORD_W-1:8]};

  assign r_mode = 3'b010;
  assign w_mode = 3'b000;

  function automatic logic [WORD_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    cell_addr = VGA_BASE + (WORD_W'(row) * WORD_W'(COLS)) + WORD_W'(col);
  endfunction

  // Read FSM next state: request only when there is room, one idle cycle between reads
  always_comb begin
    w_rd_state_nx = r_rd_state;
    w_r_enable_nx = r_enable;
    w_push        = 1'b0;
    case (r_rd_state)
      R_IDLE: if (fifo_level != C_FULL) begin
        w_rd_state_nx = R_REQ;
        w_r_enable_nx = 1'b1;
      end
      R_REQ: if (r_ready) begin
        w_push        = (r_data[7:0] != 8'h00);
        w_rd_state_nx = R_IDLE;
        w_r_enable_nx = 1'b0;
      end
    endcase
  end

  // Read FSM state and bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_state <= R_IDLE;
      r_enable   <= 1'b0;
      r_addr     <= KBD_ADDR;
    end else begin
      r_rd_state <= w_rd_state_nx;
      r_enable   <= w_r_enable_nx;
      r_addr     <= KBD_ADDR;
    end
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= r_data[7:0];
  end

  // FIFO pointers and level; simultaneous push and pop leaves level unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Write FSM next state: pop, classify, then hold the bus write until accepted
  always_comb begin
    w_wr_state_nx = r_wr_state;
    w_w_enable_nx = w_enable;
    w_w_addr_nx   = w_addr;
    w_w_data_nx   = w_data;
    w_row_nx      = cursor_row;
    w_col_nx      = cursor_col;
    w_code_nx     = r_code;
    w_is_print_nx = r_is_print;
    w_pop         = 1'b0;
`ifdef KBD_CONSOLE_CLEAR_EN
    w_clearing_nx = r_clearing;
    w_clr_idx_nx  = r_clr_idx;
`endif
    case (r_wr_state)
      W_IDLE: if (fifo_level != '0) begin
        w_pop         = 1'b1;
        w_code_nx     = r_fifo_mem[r_rd_ptr];
        w_wr_state_nx = W_DEC;
      end
      W_DEC: begin
        w_wr_state_nx = W_IDLE;
        w_is_print_nx = 1'b0;
        if (r_code == C_NL) begin
          w_col_nx = '0;
          w_row_nx = (cursor_row == C_LAST_ROW) ? '0 : cursor_row + 1'b1;
        end else if (r_code == C_BS) begin
          if (cursor_row != '0 || cursor_col != '0) begin
            if (cursor_col == '0) begin
              w_col_nx = C_LAST_COL;
              w_row_nx = cursor_row - 1'b1;
            end else begin
              w_col_nx = cursor_col - 1'b1;
            end
            w_w_addr_nx   = cell_addr(w_row_nx, w_col_nx);
            w_w_data_nx   = {{(WORD_W-8){1'b0}}, C_SP};
            w_w_enable_nx = 1'b1;
            w_wr_state_nx = W_REQ;
          end
        end else begin
          w_w_addr_nx   = cell_addr(cursor_row, cursor_col);
          w_w_data_nx   = {{(WORD_W-8){1'b0}}, r_code};
          w_w_enable_nx = 1'b1;
          w_is_print_nx = 1'b1;
          w_wr_state_nx = W_REQ;
        end
      end
      W_REQ: if (w_ready) begin
        w_w_enable_nx = 1'b0;
        w_is_print_nx = 1'b0;
        w_wr_state_nx = W_IDLE;
        // Printable characters advance the cursor only once the write lands
        if (r_is_print) begin
          if (cursor_col == C_LAST_COL) begin
            w_col_nx = '0;
            w_row_nx = (cursor_row == C_LAST_ROW) ? '0 : cursor_row + 1'b1;
          end else begin
            w_col_nx = cursor_col + 1'b1;
          end
        end
`ifdef KBD_CONSOLE_CLEAR_EN
        if (r_clearing) begin
          if (r_clr_idx == WORD_W'(ROWS * COLS - 1)) begin
            w_clearing_nx = 1'b0;
          end else begin
            w_clr_idx_nx  = r_clr_idx + 1'b1;
            w_wr_state_nx = W_CLR;
          end
        end
`endif
      end
`ifdef KBD_CONSOLE_CLEAR_EN
      W_CLR: begin
        w_w_addr_nx   = VGA_BASE + r_clr_idx;
        w_w_data_nx   = {{(WORD_W-8){1'b0}}, C_SP};
        w_w_enable_nx = 1'b1;
        w_wr_state_nx = W_REQ;
      end
`endif
      default: w_wr_state_nx = W_IDLE;
    endcase
  end

  // Write FSM state, cursor and bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef KBD_CONSOLE_CLEAR_EN
      r_wr_state <= W_CLR;
      r_clearing <= 1'b1;
      r_clr_idx  <= '0;
`else
      r_wr_state <= W_IDLE;
`endif
      w_enable   <= 1'b0;
      w_addr     <= VGA_BASE;
      w_data     <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      r_code     <= '0;
      r_is_print <= 1'b0;
    end else begin
`ifdef KBD_CONSOLE_CLEAR_EN
      r_clearing <= w_clearing_nx;
      r_clr_idx  <= w_clr_idx_nx;
`endif
      r_wr_state <= w_wr_state_nx;
      w_enable   <= w_w_enable_nx;
      w_addr     <= w_w_addr_nx;
      w_data     <= w_w_data_nx;
      cursor_row <= w_row_nx;
      cursor_col <= w_col_nx;
      r_code     <= w_code_nx;
      r_is_print <= w_is_print_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_console_mcu.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_console_mcu
// Description : Scoreboard bench for kbd_console_mcu (COLS=4, ROWS=2). A
//               keyboard model answers reads from a key queue; expected VGA
//               writes are queued with the stimulus and popped by a monitor.
//               Define KBD_CONSOLE_CLEAR_EN to also expect the clear pass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_console_mcu;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] r_data = '0;
  logic        r_ready = 1'b0;
  logic        w_ready = 1'b0;
  logic        r_enable, w_enable;
  logic [31:0] r_addr, w_addr, w_data;
  logic [2:0]  r_mode, w_mode;
  logic [0:0]  cursor_row;
  logic [1:0]  cursor_col;
  logic [2:0]  fifo_level;

  kbd_console_mcu #(
    .WORD_W(32), .KBD_ADDR(32'h0000_1000), .VGA_BASE(32'h0000_2000),
    .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .r_data(r_data), .r_ready(r_ready), .w_ready(w_ready),
    .r_enable(r_enable), .r_addr(r_addr), .r_mode(r_mode),
    .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data), .w_mode(w_mode),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  kbd_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Keyboard device: answer each requested read with the next key, else 0
  always @(negedge clk) begin
    if (r_enable) begin
      r_ready = 1'b1;
      if (kbd_q.size() != 0) r_data = {24'h0, kbd_q.pop_front()};
      else                   r_data = 32'h0;
    end else begin
      r_ready = 1'b0;
    end
  end

  // Monitor: every accepted write is matched against the scoreboard queue
  always @(negedge clk) begin
    if (rst && w_enable && w_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", w_addr, w_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("vga_write{addr,data}", {w_addr, w_data}, mon_e);
      end
    end
  end

  task automatic drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || kbd_q.size() != 0 || fifo_level != 0 || w_enable) && c < 600) begin
      tick(1);
      c++;
    end
    if (c >= 600) begin
      n_total++;
      $display("FAIL %s_timeout: %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(8);
  endtask

  task automatic push_clear();
`ifdef KBD_CONSOLE_CLEAR_EN
    for (int i = 0; i < ROWS * COLS; i++) exp_q.push_back({32'(32'h2000 + i), 32'h20});
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    w_ready = 1'b1;
    tick(2);
    push_clear();
    rst = 1'b1;
    drain("clear");
  endtask

  int          max_lvl;
  int          full_reads;
  int          unstable;
  int          c;

  initial begin
    // Reset state, sampled while reset is held
    tick(3);
    chk("rst_r_enable", r_enable, 0);
    chk("rst_w_enable", w_enable, 0);
    chk("rst_r_addr", r_addr, 32'h1000);
    chk("rst_w_addr", w_addr, 32'h2000);
    chk("rst_w_data", w_data, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("r_mode", r_mode, 3'b010);
    chk("w_mode", w_mode, 3'b000);

    // Release reset (clear pass expected when enabled), then idle at origin
    do_reset();
    chk("post_reset_cursor", {cursor_row, cursor_col}, 0);

    // Basic echo
    kbd_q.push_back(8'h41);
    exp_q.push_back({32'h2000, 32'h41});
    drain("echo");
    chk("echo_cursor", {cursor_row, cursor_col}, {1'b0, 2'd1});

    // Screen wrap: 9 characters over 8 cells
    do_reset();
    for (int i = 0; i < 9; i++) begin
      kbd_q.push_back(8'(8'h61 + i));
      exp_q.push_back({32'(32'h2000 + (i % 8)), 32'(8'h61 + i)});
    end
    drain("wrap");
    chk("wrap_cursor", {cursor_row, cursor_col}, {1'b0, 2'd1});

    // Backspace at origin is a no-op
    do_reset();
    kbd_q.push_back(8'h08);
    drain("bs_origin");
    chk("bs_origin_cursor", {cursor_row, cursor_col}, 0);

    // Char + newline, then backspace across the row boundary
    kbd_q.push_back(8'h41);
    kbd_q.push_back(8'h0A);
    exp_q.push_back({32'h2000, 32'h41});
    drain("newline");
    chk("newline_cursor", {cursor_row, cursor_col}, {1'b1, 2'd0});
    kbd_q.push_back(8'h08);
    exp_q.push_back({32'h2003, 32'h20});
    drain("backspace");
    chk("backspace_cursor", {cursor_row, cursor_col}, {1'b0, 2'd3});
    kbd_q.push_back(8'h0A);
    drain("newline2");
    chk("newline2_cursor", {cursor_row, cursor_col}, {1'b1, 2'd0});
    kbd_q.push_back(8'h0A);
    drain("newline_wrap");
    chk("newline_wrap_cursor", {cursor_row, cursor_col}, 0);

    // Backpressure: stall writes while keys arrive
    do_reset();
    w_ready = 1'b0;
    max_lvl = 0; full_reads = 0; unstable = 0;
    for (int i = 0; i < 6; i++) begin
      kbd_q.push_back(8'(8'h31 + i));
      exp_q.push_back({32'(32'h2000 + i), 32'(8'h31 + i)});
    end
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (fifo_level == 3'd4 && r_enable) full_reads++;
      if (w_enable && (w_addr != 32'h2000 || w_data != 32'h31)) unstable++;
    end
    chk("bp_max_level", max_lvl, DEPTH);
    chk("bp_read_while_full", full_reads, 0);
    chk("bp_stall_unstable", unstable, 0);
    chk("bp_keys_left", kbd_q.size(), 1);
    chk("bp_w_enable_held", w_enable, 1);
    w_ready = 1'b1;
    drain("backpressure");
    chk("bp_cursor", {cursor_row, cursor_col}, {1'b1, 2'd2});

    // Reset in the middle of a stalled write with two codes buffered
    do_reset();
    w_ready = 1'b0;
    kbd_q.push_back(8'h31);
    kbd_q.push_back(8'h32);
    kbd_q.push_back(8'h33);
    c = 0;
    while (!(fifo_level == 3'd2 && w_enable) && c < 100) begin
      tick(1);
      c++;
    end
    chk("midrst_setup_reached", (c < 100), 1);
    rst = 1'b0;
    tick(1);
    chk("midrst_w_enable", w_enable, 0);
    chk("midrst_r_enable", r_enable, 0);
    chk("midrst_fifo_level", fifo_level, 0);
    chk("midrst_cursor", {cursor_row, cursor_col}, 0);
    push_clear();
    rst = 1'b1;
    w_ready = 1'b1;
    drain("midrst");
    chk("midrst_final_cursor", {cursor_row, cursor_col}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/kbd_console_mcu.md
Name: kbd_console_mcu

Overview:
- Parametrised successor to the single-character keyboard-to-VGA mover.
- Polls the keyboard port over the shared memory bus and buffers key codes in an internal FIFO.
- Interprets each code as a console character (printable, newline, backspace) and writes it into the VGA character memory at a tracked cursor position with row/screen wrap-around.
- Sits between the bus master ports and the KBD/VGA memory-mapped devices, replacing the fixed-address, one-shot mover.

Parameters:
- WORD_W, 32: bus data/address width.
- KBD_ADDR, 32'h0000_1000: keyboard read address.
- VGA_BASE, 32'h0000_2000: address of character cell (row 0, col 0).
- COLS, 80: characters per row (>=2).
- ROWS, 30: rows per screen (>=2).
- FIFO_DEPTH, 4: key-code buffer entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- r_data  in  WORD_W  read data; key code in [7:0], 0 = no key
- r_ready  in  1  read completed, r_data valid this cycle
- w_ready  in  1  write accepted this cycle
- r_enable  out  1  read request
- r_addr  out  WORD_W  read address
- r_mode  out  3  constant 3'b010
- w_enable  out  1  write request
- w_addr  out  WORD_W  write address
- w_data  out  WORD_W  {zero-extend, char[7:0]}
- w_mode  out  3  constant 3'b000
- cursor_row  out  $clog2(ROWS)  current row
- cursor_col  out  $clog2(COLS)  current column
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries buffered

Behaviour:
- Reset, sampled on posedge clk while rst==0, takes effect that edge:
  - r_enable=0, w_enable=0, r_addr=KBD_ADDR, w_addr=VGA_BASE, w_data=0.
  - Cursor (0,0), FIFO empty, fifo_level=0.
  - Read FSM to R_IDLE, write FSM to W_IDLE.
- Reset mid-transaction drops enables at that edge. Any in-flight code or write is discarded.
- All outputs are registered.

Read FSM:
- R_IDLE: if FIFO not full, go to R_REQ and assert r_enable next cycle.
- R_REQ: r_enable=1 and r_addr=KBD_ADDR, held until r_ready=1.
  - On r_ready: if r_data[7:0]!=0, push it. Always go to R_IDLE; r_enable drops the following cycle.
  - Result: at least one idle cycle between consecutive reads.
- A push cannot overflow: a read is issued only when FIFO not full, and pops only add space.

Write FSM:
- W_IDLE: if FIFO not empty, pop the head and go to W_DEC.
- W_DEC (1 cycle), classify the code:
  - 0x0A newline: col=0, row=(row+1) mod ROWS. No bus write. Back to W_IDLE.
  - 0x08 backspace at (0,0): no-op, back to W_IDLE.
  - 0x08 backspace otherwise: cursor steps back one cell (col 0 moves to COLS-1 of row-1). Load w_data=0x20 at the new cell, go to W_REQ.
  - Other code: load w_data=code at the current cell, go to W_REQ. Cursor advances after acceptance.
- W_REQ: w_enable=1, with w_addr=VGA_BASE+row*COLS+col and w_data held stable until w_ready=1.
  - On w_ready: w_enable=0 next cycle, go to W_IDLE.
  - For a printable character, the cursor advances on that edge: col+1; at col==COLS-1 it becomes col=0, row+1; at (ROWS-1,COLS-1) it wraps to (0,0).
- Address arithmetic is at WORD_W width, with row*COLS computed unsigned.

Concurrency:
- Read and write FSMs run concurrently; r_enable and w_enable may both be 1.
- Simultaneous push and pop in one cycle: fifo_level unchanged, data order preserved.
- Bus latency: minimum 3 cycles from key capture to w_enable (push, pop, decode).

Optional Feature:
- Macro: KBD_CONSOLE_CLEAR_EN.
- When defined, after reset the write FSM enters W_CLR before W_IDLE.
  - W_CLR writes 0x20 to every cell 0..ROWS*COLS-1 in address order, using the W_REQ handshake for each cell.
  - Cursor stays (0,0) afterwards.
  - The read FSM runs normally during the clear and keys buffer, up to FIFO_DEPTH.
- When undefined, no clear pass; the write FSM starts in W_IDLE.

Test Plan:
- Clear pass (KBD_CONSOLE_CLEAR_EN on, ROWS=2, COLS=4): release reset, w_ready=1 every cycle -> 8 writes of 0x20 to 0x2000..0x2007, then idle with cursor (0,0).
- Basic echo: keyboard returns 0x41 then 0x00 repeatedly, w_ready immediate -> exactly one write, addr 0x2000, data 0x41; cursor (0,1).
- Wrap (COLS=4, ROWS=2): feed 9 printable codes 0x61..0x69 -> addresses 0x2000..0x2007 then 0x2000; final cursor (0,1).
- Newline/backspace: keys 0x41, 0x0A, 0x08 -> write 0x41@0x2000; newline gives cursor (1,0); backspace gives cursor (0,COLS-1) and a write of 0x20@VGA_BASE+COLS-1.
- Backpressure: hold w_ready=0 for 50 cycles while keys 0x31..0x36 arrive -> fifo_level saturates at 4, r_enable stays 0 while full, no codes lost or reordered after w_ready released; w_addr/w_data stable while stalled.
- Reset mid-op: assert rst=0 for one edge during W_REQ with FIFO level 2 -> next cycle w_enable=0, r_enable=0, fifo_level=0, cursor (0,0).
